// File: rtl/au_pkg.sv
// au_pkg -- shared definitions for the arithmetic-unit issuer.
//   au_op_e    : ALU opcode encoding (ADD, SUB, MULT, DIV)
//   au_state_e : issuer FSM states (IDLE, WAIT, RESP)
//   DEF_LAT_*  : default arithmetic-unit latencies in cycles
//   lat_max3() : largest of three latencies, used to size the wait counter
package au_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MULT = 2'b10,
        OP_DIV  = 2'b11
    } au_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } au_state_e;

    localparam int unsigned DEF_LAT_ADDSUB = 1;
    localparam int unsigned DEF_LAT_MULT   = 32;
    localparam int unsigned DEF_LAT_DIV    = 32;

    function automatic int unsigned lat_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/au_issuer_if.sv
// au_issuer_if -- bundles the request, arithmetic-unit, response and status
// signals of the issuer.
//   slave  : the issuer's view (consumes requests and AU results, produces
//            AU operands, responses and busy)
//   master : the surrounding system's view (requester, AU and consumer)
interface au_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [31:0] au_a;
    logic [31:0] au_b;
    logic [1:0]  au_op;
    logic [31:0] au_s;
    logic [31:0] au_hi;
    logic [31:0] au_lo;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_zero;
    logic        rsp_divzero;

    logic        busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output au_a, au_b, au_op,
        input  au_s, au_hi, au_lo,
        output rsp_valid, rsp_op, rsp_hi, rsp_lo, rsp_zero, rsp_divzero,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  au_a, au_b, au_op,
        output au_s, au_hi, au_lo,
        input  rsp_valid, rsp_op, rsp_hi, rsp_lo, rsp_zero, rsp_divzero,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/au_wait_counter.sv
// au_wait_counter -- loadable down-counter that times the arithmetic unit.
//   clk, rst : clock and synchronous active-high reset
//   load     : load 'value' this cycle (takes priority over counting)
//   value    : cycles remaining minus one for the operation just issued
//   done     : counter is at zero
// The counter decrements whenever it is non-zero and rests at zero, so it
// only moves while an operation is outstanding.
module au_wait_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/au_issuer.sv
// au_issuer -- issues one request at a time to a fixed-latency arithmetic
// unit and returns the captured result through a valid/ready response.
//   clk, rst : clock and synchronous active-high reset
//   bus      : au_issuer_if.slave
//     req_*  : request handshake (op, unsigned operands a/b)
//     au_*   : operands/opcode driven to the AU, results read back
//     rsp_*  : response handshake (op, hi/lo result, zero and div-by-zero flags)
//     busy   : FSM is not IDLE
// A DIV with b=0 never reaches the AU: it is answered directly with
// hi=a, lo=all-ones and the divzero flag, and the AU operands are left alone.
module au_issuer
    import au_pkg::*;
#(
    parameter int unsigned LAT_ADDSUB = DEF_LAT_ADDSUB,
    parameter int unsigned LAT_MULT   = DEF_LAT_MULT,
    parameter int unsigned LAT_DIV    = DEF_LAT_DIV
) (
    input  logic       clk,
    input  logic       rst,
    au_issuer_if.slave bus
);

    localparam int unsigned LAT_MAX = lat_max3(LAT_ADDSUB, LAT_MULT, LAT_DIV);
    localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

    // A zero latency would require capturing in the accept cycle itself.
    if (LAT_ADDSUB < 1 || LAT_MULT < 1 || LAT_DIV < 1) begin : g_lat_check
        $error("au_issuer: every latency parameter must be at least 1");
    end

    au_state_e   state_q, state_d;

    logic        accept;
    logic        div_by_zero;
    logic        capture;
    logic        cnt_load;
    logic        cnt_done;
    logic [CNT_W-1:0] cnt_value;

    logic [31:0] au_a_q, au_a_d;
    logic [31:0] au_b_q, au_b_d;
    au_op_e      au_op_q, au_op_d;

    logic [1:0]  rsp_op_q, rsp_op_d;
    logic [31:0] rsp_hi_q, rsp_hi_d;
    logic [31:0] rsp_lo_q, rsp_lo_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_divzero_q, rsp_divzero_d;

    logic [31:0] cap_hi;
    logic [31:0] cap_lo;

    always_comb begin
        div_by_zero = (au_op_e'(bus.req_op) == OP_DIV) && (bus.req_b == '0);
        accept      = bus.req_valid && (state_q == ST_IDLE);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = div_by_zero ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.busy      = (state_q != ST_IDLE);
        cnt_load      = accept && !div_by_zero;
        capture       = (state_q == ST_WAIT) && cnt_done;
    end

    // Counter is loaded with LAT-1 so that, counting the WAIT cycle in which
    // it reads zero, capture lands exactly LAT edges after the accept edge.
    always_comb begin
        case (au_op_e'(bus.req_op))
            OP_ADD, OP_SUB: cnt_value = CNT_W'(LAT_ADDSUB - 1);
            OP_MULT:        cnt_value = CNT_W'(LAT_MULT - 1);
            default:        cnt_value = CNT_W'(LAT_DIV - 1);
        endcase
    end

    au_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .value (cnt_value),
        .done  (cnt_done)
    );

    // Result selection: add/sub produce a single word in lo.
    always_comb begin
        if (au_op_q == OP_ADD || au_op_q == OP_SUB) begin
            cap_hi = '0;
            cap_lo = bus.au_s;
        end else begin
            cap_hi = bus.au_hi;
            cap_lo = bus.au_lo;
        end
    end

    always_comb begin
        au_a_d        = au_a_q;
        au_b_d        = au_b_q;
        au_op_d       = au_op_q;
        rsp_op_d      = rsp_op_q;
        rsp_hi_d      = rsp_hi_q;
        rsp_lo_d      = rsp_lo_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_divzero_d = rsp_divzero_q;

        if (accept && div_by_zero) begin
            rsp_op_d      = bus.req_op;
            rsp_hi_d      = bus.req_a;
            rsp_lo_d      = 32'hFFFF_FFFF;
            rsp_zero_d    = 1'b0;
            rsp_divzero_d = 1'b1;
        end else if (accept) begin
            au_a_d  = bus.req_a;
            au_b_d  = bus.req_b;
            au_op_d = au_op_e'(bus.req_op);
        end

        if (capture) begin
            rsp_op_d      = au_op_q;
            rsp_hi_d      = cap_hi;
            rsp_lo_d      = cap_lo;
            rsp_zero_d    = (cap_hi == '0) && (cap_lo == '0);
            rsp_divzero_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            au_a_q        <= '0;
            au_b_q        <= '0;
            au_op_q       <= OP_ADD;
            rsp_op_q      <= '0;
            rsp_hi_q      <= '0;
            rsp_lo_q      <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_divzero_q <= 1'b0;
        end else begin
            au_a_q        <= au_a_d;
            au_b_q        <= au_b_d;
            au_op_q       <= au_op_d;
            rsp_op_q      <= rsp_op_d;
            rsp_hi_q      <= rsp_hi_d;
            rsp_lo_q      <= rsp_lo_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_divzero_q <= rsp_divzero_d;
        end
    end

    assign bus.au_a        = au_a_q;
    assign bus.au_b        = au_b_q;
    assign bus.au_op       = au_op_q;
    assign bus.rsp_op      = rsp_op_q;
    assign bus.rsp_hi      = rsp_hi_q;
    assign bus.rsp_lo      = rsp_lo_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_divzero = rsp_divzero_q;

endmodule
